// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Types and constants shared by the UART receive controller and the
//   upcoming transmit controller.
//
//   Contents:
//     uart_state_e      - receiver FSM states (3-bit encoding)
//     OVERSAMPLE        - oversample ticks per bit (fixed at 16)
//     MID_SAMPLE        - tick index of the middle of the start bit
//     LAST_SAMPLE       - tick index of the end of a bit period
//     DATA_BITS         - data bits per frame (8N1)
//     shift_in_lsb      - helper that shifts a line bit into a byte
//                         received LSB first
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_BITS);

    typedef logic [SCNT_W-1:0]    scnt_t;
    typedef logic [BCNT_W-1:0]    bcnt_t;
    typedef logic [DATA_BITS-1:0] byte_t;

    // Sample 7 of 0..15 lies in the middle of the start bit; every later
    // bit is sampled a full bit period (16 ticks) after that point.
    localparam scnt_t MID_SAMPLE  = scnt_t'(OVERSAMPLE / 2 - 1);
    localparam scnt_t LAST_SAMPLE = scnt_t'(OVERSAMPLE - 1);
    localparam bcnt_t LAST_BIT    = bcnt_t'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

    // The line carries the LSB first, so each new bit enters at the MSB
    // and after DATA_BITS shifts the first bit sits in bit 0.
    function automatic byte_t shift_in_lsb(input byte_t sh, input logic b);
        return {b, sh[DATA_BITS-1:1]};
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//   Oversample tick generator. Counts 0..CLKS_PER_TICK-1 while run is high
//   and pulses tick for one clk at terminal count. While run is low the
//   counter is held at 0, so the first tick after run rises arrives exactly
//   CLKS_PER_TICK cycles later (phase-aligned to whatever raised run).
//
//   Parameters:
//     CLKS_PER_TICK  clk cycles per oversample tick
//   Ports:
//     clk    in   core clock
//     reset  in   asynchronous, active-high reset
//     run    in   count enable; low clears the counter
//     tick   out  one-cycle pulse at terminal count
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLKS_PER_TICK = 326
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_TICK - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == TERMINAL);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//   UART receiver for the MEM-stage peripheral bus. Synchronises the serial
//   pin, oversamples it 16x and deserialises 8N1 frames (LSB first). A
//   received byte is held in rx_data until the CPU acknowledges it with
//   rd_ack; overrun and frame errors are sticky until err_clr.
//
//   Parameters:
//     CLKS_PER_TICK  clk cycles per oversample tick (50 MHz / (9600*16))
//   Ports:
//     clk        in   core clock
//     reset      in   asynchronous, active-high reset
//     uart_rx    in   serial line, idle high, asynchronous to clk
//     rd_ack     in   pulse: CPU consumed rx_data, clears rx_valid
//     err_clr    in   pulse: clears overrun and frame_err
//     irq_en     in   interrupt enable
//     rx_data    out  last accepted byte
//     rx_valid   out  rx_data holds an unacknowledged byte
//     rx_busy    out  receiver is not idle
//     overrun    out  sticky: byte dropped because rx_valid was still set
//     frame_err  out  sticky: stop bit sampled low
//     rx_irq     out  registered rx_valid & irq_en
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int CLKS_PER_TICK = 326
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       rd_ack,
    input  logic       err_clr,
    input  logic       irq_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       overrun,
    output logic       frame_err,
    output logic       rx_irq
);

    import uart_pkg::*;

    // ------------------------------------------------------------------
    // Input synchroniser. Both flops reset to 1 so a reset never looks
    // like a start edge.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Oversample tick: runs whenever the receiver is out of IDLE, so the
    // tick phase is set by the cycle the FSM enters START.
    // ------------------------------------------------------------------
    uart_state_e state;
    uart_state_e state_d;
    logic        tick_run;
    logic        tick;

    assign tick_run = (state != IDLE);

    uart_baud_tick #(
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .run   (tick_run),
        .tick  (tick)
    );

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    scnt_t scnt;
    scnt_t scnt_d;
    bcnt_t bcnt;
    bcnt_t bcnt_d;
    byte_t shreg;
    byte_t shreg_d;
    logic  deliver;     // registered: byte in shreg is delivered this cycle
    logic  deliver_d;
    logic  ferr_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            scnt    <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            deliver <= 1'b0;
        end else begin
            state   <= state_d;
            scnt    <= scnt_d;
            bcnt    <= bcnt_d;
            shreg   <= shreg_d;
            deliver <= deliver_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        scnt_d    = scnt;
        bcnt_d    = bcnt;
        shreg_d   = shreg;
        deliver_d = 1'b0;
        ferr_set  = 1'b0;

        case (state)
            IDLE: begin
                scnt_d = '0;
                bcnt_d = '0;
                if (!rxs) begin
                    state_d = START;
                end
            end

            START: begin
                if (tick) begin
                    if (scnt == MID_SAMPLE) begin
                        // Line still low mid-bit: real start bit.
                        // Otherwise a glitch, dropped without any flag.
                        scnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        scnt_d = scnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (scnt == LAST_SAMPLE) begin
                        scnt_d  = '0;
                        shreg_d = shift_in_lsb(shreg, rxs);
                        if (bcnt == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            bcnt_d = bcnt + 1'b1;
                        end
                    end else begin
                        scnt_d = scnt + 1'b1;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (scnt == LAST_SAMPLE) begin
                        scnt_d = '0;
                        if (rxs) begin
                            deliver_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            // Byte discarded; wait for the line to go
                            // high so a held break flags only once.
                            ferr_set = 1'b1;
                            state_d  = WAIT_IDLE;
                        end
                    end else begin
                        scnt_d = scnt + 1'b1;
                    end
                end
            end

            WAIT_IDLE: begin
                scnt_d = '0;
                if (rxs) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

    // ------------------------------------------------------------------
    // CPU-facing holding register and status flags
    // ------------------------------------------------------------------
    logic accept;
    logic overrun_set;

    // An ack in the delivery cycle frees the holding register in time for
    // the new byte, so that case is a clean hand-over, not an overrun.
    assign accept      = deliver && (!rx_valid || rd_ack);
    assign overrun_set = deliver && rx_valid && !rd_ack;

    // NOTE: rx_data is reset along with the flags because software may
    // read it before the first frame and must see 0x00, not X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_irq    <= 1'b0;
        end else begin
            rx_irq <= rx_valid & irq_en;

            if (accept) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rd_ack && !deliver) begin
                rx_valid <= 1'b0;
            end

            // Set has priority over clear for both sticky flags.
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end

            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule
